// File: rtl/fg_config_sequencer.sv
// fg_config_sequencer
// Collects a byte-wide write stream into a shadow configuration word and commits
// it to the function generator's config bus only at a safe point: a sync pulse
// from the generator, an immediate request, or any time the generator is
// stopped. It also drives the generator's enable line.
//
// Optional feature macro: FG_CFG_RESTART_EN
//   defined   : enable_o drops low for the commit cycle whenever a commit
//               happens with run_i high, restarting the generator on the new word
//   undefined : enable_o is simply run_i delayed by one cycle
//
// Ports
//   clk_i        in   clock, rising edge
//   rstn_i       in   async active-low reset
//   start_i      in   begin a new frame (byte index back to 0)
//   wr_strb_i    in   byte valid, one byte per high cycle
//   wr_data_i    in   byte data, MSB byte of the word first
//   sync_i       in   commit-point pulse from the generator
//   immediate_i  in   commit the armed word without waiting for sync_i
//   run_i        in   host run request
//   err_clr_i    in   clears err_o
//   enable_o     out  generator enable
//   CR_bus_o     out  active configuration word
//   busy_o       out  FSM not in IDLE
//   ack_o        out  one-cycle pulse with each commit
//   err_o        out  sticky frame error
//
// state | meaning
// IDLE  | waiting for start_i; stray bytes flag an error
// LOAD  | storing bytes into the shadow word; idle timer running
// ARMED | full word held; waiting for a safe commit point
module fg_config_sequencer #(
  parameter int                             CONFIG_REG_BITWIDTH = 64,
  parameter int                             TIMEOUT_CYCLES      = 1023,
  parameter logic [CONFIG_REG_BITWIDTH-1:0] CR_RESET            = '0
) (
  input  logic                           clk_i,
  input  logic                           rstn_i,
  input  logic                           start_i,
  input  logic                           wr_strb_i,
  input  logic [7:0]                     wr_data_i,
  input  logic                           sync_i,
  input  logic                           immediate_i,
  input  logic                           run_i,
  input  logic                           err_clr_i,
  output logic                           enable_o,
  output logic [CONFIG_REG_BITWIDTH-1:0] CR_bus_o,
  output logic                           busy_o,
  output logic                           ack_o,
  output logic                           err_o
);

  localparam int NBYTES = CONFIG_REG_BITWIDTH / 8;
  localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);
  localparam logic [15:0]      TO_LOAD  = 16'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    ARMED = 2'd2
  } state_t;

  state_t state, state_next;

  logic [IDX_W-1:0]               idx;
  logic [IDX_W-1:0]               store_idx;
  logic [15:0]                    idle_cnt;
  logic [CONFIG_REG_BITWIDTH-1:0] shadow;
  logic                           store;
  logic                           commit;
  logic                           err_set;
  logic                           restart;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    store      = 1'b0;
    store_idx  = idx;
    commit     = 1'b0;
    err_set    = 1'b0;
    restart    = 1'b0;
    case (state)
      IDLE: begin
        if (start_i) begin
          state_next = LOAD;
          restart    = 1'b1;
          store      = wr_strb_i;
          store_idx  = '0;
        end else if (wr_strb_i) begin
          err_set = 1'b1;
        end
      end
      LOAD: begin
        if (start_i) begin
          restart   = 1'b1;
          store     = wr_strb_i;
          store_idx = '0;
        end else if (wr_strb_i) begin
          store = 1'b1;
        end else if (idle_cnt <= 16'd1) begin
          // idle timer hit terminal count: abandon the frame
          state_next = IDLE;
          err_set    = 1'b1;
        end
      end
      ARMED: begin
        if (start_i) begin
          // a new frame drops the pending commit
          state_next = LOAD;
          restart    = 1'b1;
          err_set    = 1'b1;
          store      = wr_strb_i;
          store_idx  = '0;
        end else begin
          if (wr_strb_i) err_set = 1'b1;
          if (sync_i || immediate_i || !enable_o) begin
            commit     = 1'b1;
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
    if (store && store_idx == LAST_IDX) state_next = ARMED;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      idx      <= '0;
      idle_cnt <= '0;
      shadow   <= '0;
      CR_bus_o <= CR_RESET;
      ack_o    <= 1'b0;
      err_o    <= 1'b0;
      enable_o <= 1'b0;
    end else begin
      if (store)
        idx <= (store_idx == LAST_IDX) ? '0 : store_idx + 1'b1;
      else if (restart || state_next == IDLE)
        idx <= '0;

      if (store || restart)
        idle_cnt <= TO_LOAD;
      else if (state == LOAD && idle_cnt != 16'd0)
        idle_cnt <= idle_cnt - 16'd1;

      for (int b = 0; b < NBYTES; b++) begin
        if (store && store_idx == IDX_W'(b))
          shadow[CONFIG_REG_BITWIDTH-1-8*b -: 8] <= wr_data_i;
      end

      if (commit) CR_bus_o <= shadow;
      ack_o <= commit;

      // a new error beats a simultaneous clear
      if (err_set)        err_o <= 1'b1;
      else if (err_clr_i) err_o <= 1'b0;

`ifdef FG_CFG_RESTART_EN
      enable_o <= run_i & ~commit;
`else
      enable_o <= run_i;
`endif
    end
  end

  assign busy_o = (state != IDLE);

endmodule

// File: tb/tb_fg_config_sequencer.sv
module tb_fg_config_sequencer;

  localparam logic [63:0] CR_RST = 64'h5A5A_0000_FFFF_1234;
`ifdef FG_CFG_RESTART_EN
  localparam bit RESTART = 1'b1;
`else
  localparam bit RESTART = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic        start_i, wr_strb_i, sync_i, immediate_i, run_i, err_clr_i;
  logic [7:0]  wr_data_i;
  logic        enable_o, busy_o, ack_o, err_o;
  logic [63:0] CR_bus_o;

  int checks = 0;
  int fails  = 0;
  logic [63:0] exp_q[$];

  fg_config_sequencer #(
    .CONFIG_REG_BITWIDTH(64),
    .TIMEOUT_CYCLES(4),
    .CR_RESET(CR_RST)
  ) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .start_i(start_i), .wr_strb_i(wr_strb_i),
    .wr_data_i(wr_data_i), .sync_i(sync_i), .immediate_i(immediate_i),
    .run_i(run_i), .err_clr_i(err_clr_i), .enable_o(enable_o),
    .CR_bus_o(CR_bus_o), .busy_o(busy_o), .ack_o(ack_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [63:0] word;
    bit          run;
    bit          imm;
    bit          use_sync;
    int          sync_wait;
    int          exp_lat;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic load_bytes(input logic [63:0] w, input int first, input int last, input bit with_start);
    for (int i = first; i <= last; i++) begin
      start_i   = with_start && (i == first);
      wr_strb_i = 1'b1;
      wr_data_i = w[63-8*i -: 8];
      tick();
    end
    start_i   = 1'b0;
    wr_strb_i = 1'b0;
  endtask

  // scoreboard: every ack must pop the word that was expected to commit
  always @(negedge clk_i) begin
    if (rstn_i === 1'b1 && ack_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_ack: got ack with bus %h expected no commit at %0t", CR_bus_o, $time);
      end else begin
        logic [63:0] w;
        w = exp_q.pop_front();
        chk("commit_word", CR_bus_o, w);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[5];
    int   lat;
    bit   got;

    vecs[0] = '{64'hA012_3456_789A_BCDE, 1'b1, 1'b0, 1'b1, 5, 6};
    vecs[1] = '{64'h0011_2233_4455_6677, 1'b0, 1'b0, 1'b0, 0, 1};
    vecs[2] = '{64'hFEDC_BA98_7654_3210, 1'b1, 1'b1, 1'b0, 0, 1};
    vecs[3] = '{64'h8000_0000_0000_0001, 1'b1, 1'b0, 1'b1, 0, 1};
    vecs[4] = '{64'h0000_0000_0000_00FF, 1'b1, 1'b0, 1'b1, 2, 3};

    rstn_i = 1'b0; start_i = 0; wr_strb_i = 0; wr_data_i = 0; sync_i = 0;
    immediate_i = 0; run_i = 0; err_clr_i = 0;
    tick(); tick();
    chk("rst_bus", CR_bus_o, CR_RST);
    chk("rst_enable", 64'(enable_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_ack", 64'(ack_o), 64'd0);
    chk("rst_err", 64'(err_o), 64'd0);
    rstn_i = 1'b1;
    tick();

    // table-driven frames
    for (int k = 0; k < 5; k++) begin
      run_i = vecs[k].run;
      immediate_i = vecs[k].imm;
      tick(); tick();
      chk("pre_busy", 64'(busy_o), 64'd0);
      load_bytes(vecs[k].word, 0, 7, 1'b1);
      chk("armed_busy", 64'(busy_o), 64'd1);
      chk("armed_ack", 64'(ack_o), 64'd0);
      exp_q.push_back(vecs[k].word);
      lat = 0;
      got = 0;
      while (lat < 20 && !got) begin
        sync_i = vecs[k].use_sync && (lat == vecs[k].sync_wait);
        tick();
        lat++;
        if (ack_o) begin
          got = 1;
          chk("ack_enable", 64'(enable_o), 64'(vecs[k].run && !RESTART));
        end
      end
      sync_i = 0;
      immediate_i = 0;
      chk("commit_lat", 64'(lat), 64'(vecs[k].exp_lat));
      tick();
      chk("post_ack", 64'(ack_o), 64'd0);
      chk("post_busy", 64'(busy_o), 64'd0);
      chk("post_enable", 64'(enable_o), 64'(vecs[k].run));
      chk("post_bus", CR_bus_o, vecs[k].word);
    end

    // sync seen before ARMED must not be remembered
    run_i = 1; tick(); tick();
    sync_i = 1;
    load_bytes(64'h0F1E_2D3C_4B5A_6978, 0, 6, 1'b1);
    sync_i = 0;
    load_bytes(64'h0F1E_2D3C_4B5A_6978, 7, 7, 1'b0);
    for (int c = 0; c < 3; c++) begin
      chk("early_sync_noack", 64'(ack_o), 64'd0);
      tick();
    end
    chk("early_sync_noack", 64'(ack_o), 64'd0);
    exp_q.push_back(64'h0F1E_2D3C_4B5A_6978);
    immediate_i = 1; tick(); immediate_i = 0;
    chk("early_sync_ack", 64'(ack_o), 64'd1);
    tick();

    // stray byte in IDLE, error vs clear priority
    wr_strb_i = 1; wr_data_i = 8'h77; tick();
    chk("stray_err", 64'(err_o), 64'd1);
    chk("stray_busy", 64'(busy_o), 64'd0);
    err_clr_i = 1; tick();
    chk("err_wins_clr", 64'(err_o), 64'd1);
    wr_strb_i = 0; tick(); err_clr_i = 0;
    chk("err_clr", 64'(err_o), 64'd0);

    // idle timeout with TIMEOUT_CYCLES=4
    load_bytes(64'hCAFE_F00D_0000_0000, 0, 2, 1'b1);
    tick(); tick(); tick();
    chk("to_busy_before", 64'(busy_o), 64'd1);
    chk("to_err_before", 64'(err_o), 64'd0);
    tick();
    chk("to_busy", 64'(busy_o), 64'd0);
    chk("to_err", 64'(err_o), 64'd1);
    chk("to_bus_hold", CR_bus_o, 64'h0F1E_2D3C_4B5A_6978);
    err_clr_i = 1; tick(); err_clr_i = 0;
    chk("to_err_clr", 64'(err_o), 64'd0);

    // silent restart in LOAD
    load_bytes(64'hDEAD_BEEF_DEAD_BEEF, 0, 2, 1'b1);
    load_bytes(64'h1357_9BDF_2468_ACE0, 0, 7, 1'b1);
    chk("load_restart_err", 64'(err_o), 64'd0);
    chk("load_restart_busy", 64'(busy_o), 64'd1);
    exp_q.push_back(64'h1357_9BDF_2468_ACE0);
    sync_i = 1; tick(); sync_i = 0;
    chk("load_restart_ack", 64'(ack_o), 64'd1);
    tick();

    // restart while armed
    load_bytes(64'hAAAA_BBBB_CCCC_DDDD, 0, 7, 1'b1);
    load_bytes(64'h1122_3344_5566_7788, 0, 0, 1'b1);
    chk("armed_restart_ack", 64'(ack_o), 64'd0);
    chk("armed_restart_err", 64'(err_o), 64'd1);
    chk("armed_restart_busy", 64'(busy_o), 64'd1);
    immediate_i = 1;
    load_bytes(64'h1122_3344_5566_7788, 1, 7, 1'b0);
    exp_q.push_back(64'h1122_3344_5566_7788);
    tick(); immediate_i = 0;
    chk("armed_restart_ack2", 64'(ack_o), 64'd1);
    chk("armed_restart_msb", 64'(CR_bus_o[63:56]), 64'h11);
    chk("armed_restart_en", 64'(enable_o), 64'(!RESTART));
    tick();
    chk("restart_en_back", 64'(enable_o), 64'd1);
    err_clr_i = 1; tick(); err_clr_i = 0;

    // byte while armed flags error but commit still follows
    load_bytes(64'h0102_0304_0506_0708, 0, 7, 1'b1);
    wr_strb_i = 1; wr_data_i = 8'h55; tick(); wr_strb_i = 0;
    chk("armed_byte_err", 64'(err_o), 64'd1);
    chk("armed_byte_busy", 64'(busy_o), 64'd1);
    exp_q.push_back(64'h0102_0304_0506_0708);
    sync_i = 1; tick(); sync_i = 0;
    chk("armed_byte_ack", 64'(ack_o), 64'd1);
    tick();

    // reset mid-frame
    load_bytes(64'hFFEE_DDCC_BBAA_9988, 0, 3, 1'b1);
    chk("mid_busy", 64'(busy_o), 64'd1);
    #2 rstn_i = 1'b0;
    #1;
    chk("mid_rst_bus", CR_bus_o, CR_RST);
    chk("mid_rst_enable", 64'(enable_o), 64'd0);
    chk("mid_rst_busy", 64'(busy_o), 64'd0);
    chk("mid_rst_ack", 64'(ack_o), 64'd0);
    chk("mid_rst_err", 64'(err_o), 64'd0);
    tick();
    rstn_i = 1'b1;
    tick(); tick();
    load_bytes(64'h7766_5544_3322_1100, 0, 7, 1'b1);
    exp_q.push_back(64'h7766_5544_3322_1100);
    immediate_i = 1; tick(); immediate_i = 0;
    chk("after_rst_ack", 64'(ack_o), 64'd1);
    tick();

    chk("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
